// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared widths, FSM encoding and the round-robin pick
package mux4_rr_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        // descending scan so the lane closest to ptr is the last (winning) write
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/mux4_1.sv
// mux4_1: plain 4:1 single-bit multiplexer selected by {s1,s0}
module mux4_1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic s1,
    input  logic s0,
    output logic y
);
    assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter steering a shared 4:1 mux with bounded tenure
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
    output logic [N_REQ-1:0] gnt,
    output logic             s1,
    output logic             s0,
    output logic             busy,
    output logic             out
);
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
    state_t r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt, r_ptr, w_ptr_nxt, w_pick;
    logic [CNT_W-1:0] r_hold, w_hold_nxt;
    logic w_other, w_rot, w_mux;
    assign w_other = |(req & ~(N_REQ'(1) << r_sel));
    // owner gives up the lane on release, or on tenure expiry when someone is waiting
    assign w_rot = r_state == ST_GRANT && (!req[r_sel] || (r_hold == HOLD_MAX && w_other));
    assign w_ptr_nxt = w_rot ? r_sel + SEL_W'(1) : r_ptr;
    assign w_pick = rr_pick(req, w_ptr_nxt);
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt = r_sel;
        w_hold_nxt = r_hold;
        if (r_state == ST_IDLE) begin
            if (|req) begin
                w_state_nxt = ST_GRANT;
                w_sel_nxt = w_pick;
                w_hold_nxt = '0;
            end
        end else if (w_rot) begin
            w_state_nxt = |req ? ST_GRANT : ST_IDLE;
            w_sel_nxt = |req ? w_pick : r_sel;
            w_hold_nxt = '0;
        end else begin
            w_hold_nxt = (r_hold == HOLD_MAX) ? r_hold : r_hold + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel <= '0;
            r_ptr <= '0;
            r_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel <= w_sel_nxt;
            r_ptr <= w_ptr_nxt;
            r_hold <= w_hold_nxt;
        end
    end
    assign busy = r_state == ST_GRANT;
    assign gnt = busy ? N_REQ'(1) << r_sel : '0;
    assign {s1, s0} = r_sel;
    mux4_1 u_mux (
        .i0(d[0]),
        .i1(d[1]),
        .i2(d[2]),
        .i3(d[3]),
        .s1(s1),
        .s0(s0),
        .y (w_mux)
    );
    assign out = w_mux & busy;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: random and directed stimulus checked against an integer-level model
module tb_mux4_rr_arbiter;
    localparam int MAX_HOLD = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] d = 4'b0;
    logic [3:0] gnt;
    logic s1, s0, busy, out;
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int m_own = -1;
    int m_ptr = 0;
    int m_hold = 0;
    int m_sel = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .d(d),
        .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .out(out)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] others(input logic [3:0] r, input int o);
        return r & ~(4'b1 << o);
    endfunction

    // model: owner index (-1 idle), pointer, tenure count, last select
    always @(posedge clk) begin
        if (rst) begin
            m_own <= -1;
            m_ptr <= 0;
            m_hold <= 0;
            m_sel <= 0;
        end else if (m_own < 0) begin
            if (req != 4'b0) begin
                m_own <= pick(req, m_ptr);
                m_sel <= pick(req, m_ptr);
                m_hold <= 0;
            end
        end else if (!req[m_own] || (m_hold == MAX_HOLD - 1 && others(req, m_own) != 4'b0)) begin
            m_ptr <= (m_own + 1) % 4;
            m_hold <= 0;
            if (others(req, m_own) != 4'b0) begin
                m_own <= pick(others(req, m_own), (m_own + 1) % 4);
                m_sel <= pick(others(req, m_own), (m_own + 1) % 4);
            end else begin
                m_own <= -1;
            end
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold <= m_hold + 1;
        end
    end

    task automatic pin(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            pin("gnt", gnt, (m_own < 0) ? 4'b0 : 4'(1 << m_own));
            pin("sel", {2'b0, s1, s0}, 4'(m_sel));
            pin("busy", {3'b0, busy}, {3'b0, m_own >= 0});
            pin("out", {3'b0, out}, {3'b0, m_own >= 0 && d[m_sel[1:0]]});
        end
    end

    task automatic tick(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        d = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick(1'b1, 4'b1111);
        chk_en = 1'b1;
        tick(1'b1, 4'b1111);
        pin("reset_gnt", gnt, 4'b0000);
        pin("reset_sel", {2'b0, s1, s0}, 4'b0000);
        pin("reset_busy_out", {2'b0, busy, out}, 4'b0000);
        tick(1'b0, 4'b0100);
        pin("lane2_gnt", gnt, 4'b0100);
        pin("lane2_sel", {2'b0, s1, s0}, 4'b0010);
        pin("lane2_out", {3'b0, out}, {3'b0, d[2]});
        tick(1'b0, 4'b0000);
        pin("drop_gnt", gnt, 4'b0000);
        pin("drop_busy", {3'b0, busy}, 4'b0000);
        pin("drop_sel_hold", {2'b0, s1, s0}, 4'b0010);
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b1111);
        for (int g = 0; g < 5; g++)
            for (int c = 0; c < MAX_HOLD; c++) begin
                if (g != 0 || c != 0) tick(1'b0, 4'b1111);
                pin("contention_gnt", gnt, 4'(1 << (g % 4)));
            end
        tick(1'b0, 4'b1010);
        pin("handoff_gnt", gnt, 4'b0010);
        pin("handoff_busy", {3'b0, busy}, 4'b0001);
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 21; c++) begin
            tick(1'b0, 4'b0001);
            pin("solo_gnt", gnt, 4'b0001);
        end
        tick(1'b0, 4'b0011);
        pin("saturated_preempt_gnt", gnt, 4'b0010);
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b0100);
        pin("pre_reset_gnt", gnt, 4'b0100);
        tick(1'b1, 4'b0100);
        pin("mid_reset_gnt", gnt, 4'b0000);
        tick(1'b0, 4'b0110);
        pin("post_reset_gnt", gnt, 4'b0010);
        for (int n = 0; n < 600; n++) begin
            logic [3:0] q;
            q = req;
            for (int i = 0; i < 4; i++) q[i] = q[i] ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            tick($urandom_range(60) == 0, q);
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
